dm_axil_bridge: RTL
===================

Name: dm_axil_bridge

Overview:
Bridges the load/store unit's data-memory request interface to an AXI4-Lite master port. It accepts one load or one store at a time and converts the LSU's active-low byte strobe into an AXI WSTRB. It returns load data and store-completion pulses to the LSU. It sits directly downstream of the LSU and upstream of the data-memory interconnect.

Parameters:
ALIGN_ADDR, 1, 1 = force ARADDR/AWADDR[1:0] to 2'b00 (the LSU extracts sub-word lanes itself); 0 = pass the byte address through unchanged.
RESP_OKAY_ONLY, 0, 1 = treat any RRESP/BRESP other than 2'b00 as a fatal condition (assertion only); 0 = ignore the response code.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_addr  in  32  byte address; load address when load_req_valid=1, store address otherwise
load_req_valid  in  1  load request
load_req_ready  out  1  bridge can accept a load
load_data_valid  out  1  one-cycle pulse; load_data is valid
load_data  out  32  raw 32-bit word read
store_req_valid  in  1  store request
store_req_ready  out  1  bridge can accept a store
store_strb  in  4  active-low byte enable (0 = write that byte)
store_data  in  32  lane-aligned store data
store_data_valid  out  1  one-cycle pulse on store completion
m_araddr  out  32  AXI read address
m_arvalid  out  1  AXI read-address valid
m_arready  in  1  AXI read-address ready
m_rdata  in  32  AXI read data
m_rresp  in  2  AXI read response
m_rvalid  in  1  AXI read-data valid
m_rready  out  1  AXI read-data ready
m_awaddr  out  32  AXI write address
m_awvalid  out  1  AXI write-address valid
m_awready  in  1  AXI write-address ready
m_wdata  out  32  AXI write data
m_wstrb  out  4  AXI write strobe (active high)
m_wvalid  out  1  AXI write-data valid
m_wready  in  1  AXI write-data ready
m_bresp  in  2  AXI write response
m_bvalid  in  1  AXI write-response valid
m_bready  out  1  AXI write-response ready

Behaviour:
- Clock clk; reset rst is synchronous and active-high.
- On reset, all outputs are 0 and the state is IDLE. Reset mid-transaction drops every valid and ready in the next cycle. The transaction is abandoned; no pulse is returned.
- States: IDLE, RD_A, RD_D, WR_AW, WR_B.
- load_req_ready = (state==IDLE).
- store_req_ready = (state==IDLE) && !load_req_valid. Loads win simultaneous requests.
- IDLE accepting a load: latch the address, go to RD_A.
- IDLE accepting a store: latch address, data and ~store_strb, go to WR_AW.
- RD_A: m_arvalid=1; the address is held stable until m_arready. On handshake, go to RD_D.
- RD_D: m_rready=1. On m_rvalid, register m_rdata into load_data, pulse load_data_valid the next cycle, and return to IDLE.
- load_data holds its value until the next load completes.
- WR_AW: m_awvalid and m_wvalid are both raised on entry. Flags aw_done and w_done record each handshake independently; either channel may complete first, or both in the same cycle. Each valid drops after its own handshake. When both flags are set, go to WR_B.
- WR_B: m_bready=1. On m_bvalid, pulse store_data_valid the next cycle and return to IDLE.
- Zero-wait slave latency, load: accept at c0, AR handshake c1, R handshake c2, load_data_valid c3, next request accepted c3.
- Zero-wait slave latency, store: accept at c0, AW+W handshake c1, B handshake c2, store_data_valid c3.
- m_wstrb = ~store_strb. All-ones store_strb (wstrb 0000) is still issued as a write with no bytes enabled.
- Exactly one outstanding transaction. A new request is never accepted in the completion-pulse cycle unless the state is IDLE.
- Unsolicited m_rvalid or m_bvalid in the wrong state is ignored (ready=0).

Optional Feature:
DM_BRIDGE_ERR_EN: adds outputs bus_err (1 bit, sticky) and bus_err_addr (32 bits). On an R or B handshake with resp[1]=1 (SLVERR/DECERR), set bus_err and capture the latched request address. Only the first error is captured; both clear only on rst. The load/store pulses still fire normally. Without the macro these ports are absent and the response codes are ignored.

Test Plan:
- Load, zero-wait slave: req_addr=0x0000_1006, load_req_valid -> m_araddr=0x0000_1004 at c1; slave returns 0xAABBCCDD; load_data_valid pulses at c3 with load_data=0xAABBCCDD.
- SB store: store_strb=4'b1101, data=0x0000_5A00, addr=0x2001 -> m_awaddr=0x2000, m_wstrb=4'b0010, m_wdata=0x0000_5A00; store_data_valid pulses one cycle after B.
- Split handshake: m_wready at c1, m_awready held low until c4 -> m_wvalid drops at c2; m_bready is not asserted before c5; exactly one store_data_valid pulse.
- Simultaneous load_req_valid and store_req_valid in IDLE -> load is accepted (store_req_ready=0); the store is accepted in the cycle the load pulse returns to IDLE.
- Reset asserted during RD_D with m_rvalid pending -> next cycle all valids/readies=0, no load_data_valid pulse, state IDLE.
- With DM_BRIDGE_ERR_EN: B with bresp=2'b10 on addr 0x3000 -> bus_err=1, bus_err_addr=0x3000, persisting through a later OKAY transaction.

Source files
------------

// File: rtl/dm_axil_bridge.sv
// dm_axil_bridge: one-at-a-time LSU load/store to AXI4-Lite master bridge.
// Optional sticky bus-error capture is built when DM_BRIDGE_ERR_EN is defined.
module dm_axil_bridge #(
  parameter bit ALIGN_ADDR     = 1'b1,
  parameter bit RESP_OKAY_ONLY = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] req_addr,
  input  logic        load_req_valid,
  output logic        load_req_ready,
  output logic        load_data_valid,
  output logic [31:0] load_data,
  input  logic        store_req_valid,
  output logic        store_req_ready,
  input  logic [3:0]  store_strb,
  input  logic [31:0] store_data,
  output logic        store_data_valid,
  output logic [31:0] m_araddr,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rvalid,
  output logic        m_rready,
  output logic [31:0] m_awaddr,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready
`ifdef DM_BRIDGE_ERR_EN
  ,
  output logic        bus_err,
  output logic [31:0] bus_err_addr
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_D,
    WR_AW,
    WR_B
  } state_t;

  state_t state, state_n;

  logic [31:0] addr_q;
  logic [31:0] addr_in;
  logic        aw_done;
  logic        w_done;
  logic        ld_acc;
  logic        st_acc;
  logic        r_hs;
  logic        aw_hs;
  logic        w_hs;
  logic        b_hs;

  // Sub-word lanes are the LSU's job; strip them at capture time.
  assign addr_in = ALIGN_ADDR ? {req_addr[31:2], 2'b00} : req_addr;

  assign m_araddr = addr_q;
  assign m_awaddr = addr_q;

  assign r_hs  = m_rvalid  && m_rready;
  assign aw_hs = m_awvalid && m_awready;
  assign w_hs  = m_wvalid  && m_wready;
  assign b_hs  = m_bvalid  && m_bready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n         = state;
    load_req_ready  = 1'b0;
    store_req_ready = 1'b0;
    m_arvalid       = 1'b0;
    m_rready        = 1'b0;
    m_awvalid       = 1'b0;
    m_wvalid        = 1'b0;
    m_bready        = 1'b0;
    ld_acc          = 1'b0;
    st_acc          = 1'b0;
    unique case (state)
      IDLE: begin
        load_req_ready  = 1'b1;
        store_req_ready = !load_req_valid;
        if (load_req_valid) begin
          ld_acc  = 1'b1;
          state_n = RD_A;
        end else if (store_req_valid) begin
          st_acc  = 1'b1;
          state_n = WR_AW;
        end
      end
      RD_A: begin
        m_arvalid = 1'b1;
        if (m_arready) begin
          state_n = RD_D;
        end
      end
      RD_D: begin
        m_rready = 1'b1;
        if (m_rvalid) begin
          state_n = IDLE;
        end
      end
      WR_AW: begin
        m_awvalid = !aw_done;
        m_wvalid  = !w_done;
        // Either channel may finish first; leave once both are in.
        if ((aw_done || m_awready) && (w_done || m_wready)) begin
          state_n = WR_B;
        end
      end
      WR_B: begin
        m_bready = 1'b1;
        if (m_bvalid) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q           <= '0;
      m_wdata          <= '0;
      m_wstrb          <= '0;
      aw_done          <= 1'b0;
      w_done           <= 1'b0;
      load_data        <= '0;
      load_data_valid  <= 1'b0;
      store_data_valid <= 1'b0;
    end else begin
      load_data_valid  <= r_hs;
      store_data_valid <= b_hs;
      if (ld_acc || st_acc) begin
        addr_q <= addr_in;
      end
      if (st_acc) begin
        m_wdata <= store_data;
        m_wstrb <= ~store_strb;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (aw_hs) begin
        aw_done <= 1'b1;
      end
      if (w_hs) begin
        w_done <= 1'b1;
      end
      if (r_hs) begin
        load_data <= m_rdata;
      end
    end
  end

`ifdef DM_BRIDGE_ERR_EN
  logic resp_err;

  assign resp_err = (r_hs && m_rresp[1]) || (b_hs && m_bresp[1]);

  // First error wins; later errors leave the capture alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_err      <= 1'b0;
      bus_err_addr <= '0;
    end else if (!bus_err && resp_err) begin
      bus_err      <= 1'b1;
      bus_err_addr <= addr_q;
    end
  end
`endif

  resp_okay_a: assert property (
    @(posedge clk) disable iff (rst)
    !(RESP_OKAY_ONLY &&
      ((r_hs && (m_rresp != 2'b00)) ||
       (b_hs && (m_bresp != 2'b00))))
  );

endmodule
